core_ibex_debug_req_sched: RTL

CORE_IBEX_DEBUG_REQ_SCHED -- requirements
Module: core_ibex_debug_req_sched

---
 rtl/core_ibex_debug_req_sched.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/core_ibex_debug_req_sched.sv
// Debug request scheduler: boots the core after a programmable delay, then raises
// debug_req once, periodically or on core events, tracking acks and request timeouts.
module core_ibex_debug_req_sched #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_enable,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_fetch_delay,
  input  logic [CNT_W-1:0] cfg_interval,
  input  logic [CNT_W-1:0] cfg_timeout,
  input  logic             evt_wfi,
  input  logic             evt_ecall,
  input  logic             evt_ebreak,
  input  logic             debug_mode,
  input  logic             dret,
  output logic             fetch_enable,
  output logic             debug_req,
  output logic             busy,
  output logic             timeout_err,
  output logic [7:0]       req_count
);

  typedef enum logic [2:0] {
    S_BOOT, S_IDLE, S_WAIT_GAP, S_REQ, S_IN_DEBUG, S_DONE
  } state_e;

  typedef enum logic [1:0] {
    M_OFF, M_SINGLE, M_PERIODIC, M_ON_EVENT
  } mode_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fetch_enable_q, fetch_enable_d;
  logic             debug_req_q, debug_req_d;
  logic             busy_q, busy_d;
  logic             timeout_err_q, timeout_err_d;
  logic [7:0]       req_count_q, req_count_d;
  mode_e            mode;
  logic             any_evt;

  assign mode    = mode_e'(cfg_mode);
  assign any_evt = evt_wfi | evt_ecall | evt_ebreak;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    fetch_enable_d = fetch_enable_q;
    timeout_err_d  = timeout_err_q;
    req_count_d    = req_count_q;
    unique case (state_q)
      S_BOOT: begin
        if (cnt_q == cfg_fetch_delay) begin
          fetch_enable_d = 1'b1;
          cnt_d          = '0;
          state_d        = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_IDLE: begin
        if (cfg_enable) begin
          unique case (mode)
            M_SINGLE:   begin state_d = S_REQ;      cnt_d = '0; end
            M_PERIODIC: begin state_d = S_WAIT_GAP; cnt_d = '0; end
            M_ON_EVENT: if (any_evt) begin state_d = S_REQ; cnt_d = '0; end
            default:    ;
          endcase
        end
      end
      S_WAIT_GAP: begin
        if (!cfg_enable) begin
          state_d = S_IDLE;
        end else if (cnt_q == cfg_interval) begin
          state_d = S_REQ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_REQ: begin
        // Acknowledge takes priority over a timeout landing on the same cycle.
        if (debug_mode) begin
          state_d = S_IN_DEBUG;
          if (req_count_q != 8'hFF) req_count_d = req_count_q + 8'd1;
        end else if ((cfg_timeout != '0) && (cnt_q == cfg_timeout - CNT_W'(1))) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else if (!cfg_enable) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_IN_DEBUG: begin
        if (dret) begin
          unique case (mode)
            M_SINGLE:   state_d = S_DONE;
            M_PERIODIC: begin state_d = S_WAIT_GAP; cnt_d = '0; end
            default:    state_d = S_IDLE;
          endcase
        end
      end
      S_DONE: begin
        if (!cfg_enable) state_d = S_IDLE;
      end
      default: state_d = S_BOOT;
    endcase
    // Outputs are registered copies of decodes of the next state.
    debug_req_d = (state_d == S_REQ);
    busy_d      = !((state_d == S_BOOT) || (state_d == S_IDLE) || (state_d == S_DONE));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_BOOT;
      cnt_q          <= '0;
      fetch_enable_q <= 1'b0;
      debug_req_q    <= 1'b0;
      busy_q         <= 1'b0;
      timeout_err_q  <= 1'b0;
      req_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      fetch_enable_q <= fetch_enable_d;
      debug_req_q    <= debug_req_d;
      busy_q         <= busy_d;
      timeout_err_q  <= timeout_err_d;
      req_count_q    <= req_count_d;
    end
  end

  assign fetch_enable = fetch_enable_q;
  assign debug_req    = debug_req_q;
  assign busy         = busy_q;
  assign timeout_err  = timeout_err_q;
  assign req_count    = req_count_q;

endmodule
